ram_responder: RTL and testbench

- Memory-side responder for the SPARC DataPath's memory interface; the DataPath is the initiator.
- The DataPath raises mfa (memory function activate) with address, direction and access size. This block performs a big-endian byte, halfword or word access after a programmable number of wait states, then raises moc (memory operation complete).
- A byte-wide precharge port loads program and data images before the DataPath runs, replacing ad-hoc bench-side precharge.

---
 rtl/ram_responder.sv | 135 +++++++++++++
 tb/tb_ram_responder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ram_responder.sv
// Byte-addressed big-endian memory responder for the DataPath mfa/moc handshake,
// with programmable wait states and a byte-wide precharge port for image loading.
module ram_responder #(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mfa,
  input  logic              rw,
  input  logic [1:0]        data_type,
  input  logic              signed_ld,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              moc,
  output logic              misaligned,
  input  logic              pre_we,
  input  logic [ADDR_W-1:0] pre_addr,
  input  logic [7:0]        pre_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_n;
  logic              accept, finish;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] la, a1, a2, a3;
  logic              lrw, lsgn;
  logic [1:0]        lt;
  logic [31:0]       ldin;
  logic [7:0]        mem [DEPTH];
  logic              bad;
  logic [31:0]       rdata;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE: if (mfa) begin
        accept  = 1'b1;
        state_n = BUSY;
      end
      BUSY: if (cnt == 4'd0) begin
        finish  = 1'b1;
        state_n = DONE;
      end
      DONE: if (!mfa) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign a1 = la + ADDR_W'(1);
  assign a2 = la + ADDR_W'(2);
  assign a3 = la + ADDR_W'(3);

  always_comb begin
    bad = 1'b0;
    case (lt)
      2'b01:   bad = la[0];
      2'b10:   bad = (la[1:0] != 2'b00);
      2'b11:   bad = 1'b1;
      default: bad = 1'b0;
    endcase
  end

  always_comb begin
    rdata = '0;
    case (lt)
      2'b00:   rdata = {{24{lsgn & mem[la][7]}}, mem[la]};
      2'b01:   rdata = {{16{lsgn & mem[la][7]}}, mem[la], mem[a1]};
      default: rdata = {mem[la], mem[a1], mem[a2], mem[a3]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      moc        <= 1'b0;
      misaligned <= 1'b0;
      data_out   <= '0;
      cnt        <= '0;
    end else begin
      if (accept) begin
        la   <= addr;
        lrw  <= rw;
        lt   <= data_type;
        lsgn <= signed_ld;
        ldin <= data_in;
        cnt  <= WS;
      end
      if (state == BUSY && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (finish) begin
        moc        <= 1'b1;
        misaligned <= bad;
        if (!bad && lrw) data_out <= rdata;
      end
      if (state == DONE && !mfa) begin
        moc        <= 1'b0;
        misaligned <= 1'b0;
      end
    end
  end

  // Reset gates both write paths so an aborted access never reaches memory.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == IDLE && !mfa && pre_we) mem[pre_addr] <= pre_data;
      if (finish && !bad && !lrw) begin
        case (lt)
          2'b00: mem[la] <= ldin[7:0];
          2'b01: begin
            mem[la] <= ldin[15:8];
            mem[a1] <= ldin[7:0];
          end
          default: begin
            mem[la] <= ldin[31:24];
            mem[a1] <= ldin[23:16];
            mem[a2] <= ldin[15:8];
            mem[a3] <= ldin[7:0];
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: driver queues expected responses,
// monitor compares them when moc rises.
module tb_ram_responder;

  logic        clk = 1'b0;
  logic        reset, mfa, rw, signed_ld, pre_we;
  logic [1:0]  data_type;
  logic [8:0]  addr, pre_addr;
  logic [31:0] data_in, data_out;
  logic [7:0]  pre_data;
  logic        moc, misaligned;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] d;
    logic        m;
  } exp_t;
  exp_t q[$];

  ram_responder #(.ADDR_W(9), .WAIT_STATES(2)) dut (
    .clk(clk), .reset(reset), .mfa(mfa), .rw(rw), .data_type(data_type),
    .signed_ld(signed_ld), .addr(addr), .data_in(data_in), .data_out(data_out),
    .moc(moc), .misaligned(misaligned), .pre_we(pre_we), .pre_addr(pre_addr),
    .pre_data(pre_data)
  );

  always #5 clk = ~clk;

  // Monitor: compare on every rising moc
  logic moc_q = 1'b0;
  always @(negedge clk) begin
    if (moc && !moc_q) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: got data_out=%h misaligned=%b, required no response", data_out, misaligned);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (data_out !== e.d || misaligned !== e.m) begin
          errors++;
          $display("FAIL resp: got data_out=%h misaligned=%b, required %h/%b", data_out, misaligned, e.d, e.m);
        end
      end
    end
    moc_q = moc;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic precharge(input logic [8:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // rw: 1 read / 0 write; hold = extra cycles mfa stays high after moc
  task automatic access(input logic r, input logic [1:0] dt, input logic s,
                        input logic [8:0] a, input logic [31:0] din,
                        input logic [31:0] ed, input logic em, input int hold,
                        input logic prebusy, input logic precoll);
    int n;
    q.push_back('{ed, em});
    @(negedge clk);
    mfa = 1'b1; rw = r; data_type = dt; signed_ld = s; addr = a; data_in = din;
    if (precoll) begin
      pre_we = 1'b1; pre_addr = 9'd20; pre_data = 8'hAA;
    end
    @(posedge clk);
    @(negedge clk);
    pre_we = 1'b0;
    addr = ~a; data_in = ~din; data_type = ~dt;
    if (prebusy) begin
      pre_we = 1'b1; pre_addr = 9'd0; pre_data = 8'hFF;
    end
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1 pre_we = 1'b0;
    end while (!moc && n < 20);
    chk("latency", 32'(n), 32'd3);
    repeat (hold) begin
      @(posedge clk);
      #1;
      chk("hold_moc", {31'd0, moc}, 32'd1);
      chk("hold_data", data_out, ed);
    end
    @(negedge clk);
    mfa = 1'b0;
    @(posedge clk);
    #1;
    chk("moc_fall", {31'd0, moc}, 32'd0);
    chk("mis_clear", {31'd0, misaligned}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; mfa = 1'b0; rw = 1'b1; data_type = 2'b00; signed_ld = 1'b0;
    addr = '0; data_in = '0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_moc", {31'd0, moc}, 32'd0);
    chk("reset_mis", {31'd0, misaligned}, 32'd0);
    chk("reset_data", data_out, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    precharge(9'd0, 8'h8A);  precharge(9'd1, 8'h01);
    precharge(9'd2, 8'h02);  precharge(9'd3, 8'h03);
    precharge(9'd12, 8'hC0); precharge(9'd13, 8'hC1);
    precharge(9'd14, 8'hC2); precharge(9'd15, 8'hC3);
    precharge(9'd20, 8'h33);
    precharge(9'd510, 8'hF0); precharge(9'd511, 8'h7F);

    // basic reads
    access(1, 2'b10, 0, 9'd0, 0, 32'h8A010203, 0, 0, 0, 0);
    access(1, 2'b00, 1, 9'd0, 0, 32'hFFFFFF8A, 0, 0, 0, 0);
    access(1, 2'b00, 0, 9'd0, 0, 32'h0000008A, 0, 0, 0, 0);
    access(1, 2'b01, 1, 9'd2, 0, 32'h00000203, 0, 0, 0, 0);
    // writes leave data_out alone
    access(0, 2'b10, 0, 9'd8, 32'hDEADBEEF, 32'h00000203, 0, 0, 0, 0);
    access(0, 2'b00, 0, 9'd9, 32'h00000055, 32'h00000203, 0, 0, 0, 0);
    access(1, 2'b10, 0, 9'd8, 0, 32'hDE55BEEF, 0, 0, 0, 0);
    // misaligned / illegal
    access(1, 2'b10, 0, 9'd2, 0, 32'hDE55BEEF, 1, 0, 0, 0);
    access(1, 2'b01, 0, 9'd1, 0, 32'hDE55BEEF, 1, 0, 0, 0);
    access(1, 2'b11, 0, 9'd0, 0, 32'hDE55BEEF, 1, 0, 0, 0);
    access(0, 2'b11, 0, 9'd0, 32'hFFFFFFFF, 32'hDE55BEEF, 1, 0, 0, 0);
    access(0, 2'b10, 0, 9'd1, 32'h00000000, 32'hDE55BEEF, 1, 0, 0, 0);
    access(1, 2'b10, 0, 9'd0, 0, 32'h8A010203, 0, 0, 0, 0);
    // handshake hold and precharge during BUSY
    access(1, 2'b01, 0, 9'd0, 0, 32'h00008A01, 0, 5, 1, 0);
    access(1, 2'b00, 0, 9'd0, 0, 32'h0000008A, 0, 0, 0, 0);
    // mfa beats a simultaneous precharge
    access(1, 2'b00, 0, 9'd20, 0, 32'h00000033, 0, 0, 0, 1);
    access(1, 2'b00, 0, 9'd20, 0, 32'h00000033, 0, 0, 0, 0);
    // top of memory
    access(1, 2'b00, 1, 9'd511, 0, 32'h0000007F, 0, 0, 0, 0);
    access(1, 2'b01, 1, 9'd510, 0, 32'hFFFFF07F, 0, 0, 0, 0);
    access(0, 2'b01, 0, 9'd510, 32'h0000ABCD, 32'hFFFFF07F, 0, 0, 0, 0);
    access(1, 2'b01, 0, 9'd510, 0, 32'h0000ABCD, 0, 0, 0, 0);

    // reset during BUSY of a word write aborts it
    @(negedge clk);
    mfa = 1'b1; rw = 1'b0; data_type = 2'b10; addr = 9'd12; data_in = 32'h11223344;
    @(posedge clk);
    @(negedge clk);
    mfa = 1'b0; reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_moc", {31'd0, moc}, 32'd0);
    chk("abort_data", data_out, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    access(1, 2'b10, 0, 9'd12, 0, 32'hC0C1C2C3, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
